// File: rtl/bus_arbiter_rr.sv
// Multi-master, multi-slave system bus with a registered grant (fixed priority or round robin),
// slave handshake, decode-miss and timeout error responses, and pipeline hold generation.
module bus_arbiter_rr #(
    parameter int            NUM_M      = 3,
    parameter int            NUM_S      = 6,
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter int            SEL_W      = 4,
    parameter int            ARB_MODE   = 0,
    parameter int            IFU_ID     = 1,
    parameter logic [DW-1:0] IDLE_RDATA = 32'h0000_0013,
    parameter int            TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M-1:0]    m_req_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_wdata_i,
    output logic [NUM_M*DW-1:0] m_rdata_o,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic [NUM_S-1:0]    s_req_o,
    output logic [NUM_S-1:0]    s_we_o,
    output logic [NUM_S*AW-1:0] s_addr_o,
    output logic [NUM_S*DW-1:0] s_wdata_o,
    input  logic [NUM_S*DW-1:0] s_rdata_i,
    input  logic [NUM_S-1:0]    s_ack_i,
    output logic                hold_flag_o
);
    localparam int              GW        = $clog2(NUM_M);
    localparam logic [SEL_W:0]  NUM_S_L   = (SEL_W+1)'(NUM_S);
    localparam logic [7:0]      TCNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [GW-1:0]   LAST_M    = GW'(NUM_M - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d;
    logic [7:0]    tcnt_q, tcnt_d;

    logic [NUM_M-1:0] hi_req_s, g_sel_s;
    logic [GW-1:0]    win_hi_s, win_lo_s, winner_s;
    logic             g_req_s, g_we_s;
    logic [AW-1:0]    g_addr_s, addr_lo_s;
    logic [DW-1:0]    g_wdata_s, slv_rdata_s;
    logic [SEL_W-1:0] sel_s;
    logic [NUM_S-1:0] hit_s;
    logic             sel_ok_s, act_s, slv_ack_s, miss_s, tout_s, err_s, done_s, other_req_s;

    // Arbitration: first request at or above the rotating pointer, else lowest index overall.
    always_comb begin
        hi_req_s = '0;
        win_hi_s = '0;
        win_lo_s = '0;
        for (int k = 0; k < NUM_M; k++) begin
            hi_req_s[k] = m_req_i[k] & ((ARB_MODE == 0) || (GW'(k) >= rr_ptr_q));
        end
        for (int k = NUM_M - 1; k >= 0; k--) begin
            win_hi_s = hi_req_s[k] ? GW'(k) : win_hi_s;
            win_lo_s = m_req_i[k] ? GW'(k) : win_lo_s;
        end
        winner_s = (|hi_req_s) ? win_hi_s : win_lo_s;
    end

    // Granted-master mux, slave decode and routing, completion/error detection.
    always_comb begin
        g_sel_s   = '0;
        g_req_s   = 1'b0;
        g_we_s    = 1'b0;
        g_addr_s  = '0;
        g_wdata_s = '0;
        for (int k = 0; k < NUM_M; k++) begin
            g_sel_s[k] = (grant_q == GW'(k));
            g_req_s    = g_req_s | (g_sel_s[k] & m_req_i[k]);
            g_we_s     = g_we_s | (g_sel_s[k] & m_we_i[k]);
            g_addr_s   = g_addr_s | ({AW{g_sel_s[k]}} & m_addr_i[k*AW +: AW]);
            g_wdata_s  = g_wdata_s | ({DW{g_sel_s[k]}} & m_wdata_i[k*DW +: DW]);
        end
        sel_s     = g_addr_s[AW-1 -: SEL_W];
        sel_ok_s  = ({1'b0, sel_s} < NUM_S_L);
        addr_lo_s = {{SEL_W{1'b0}}, g_addr_s[AW-SEL_W-1:0]};
        // A dropped request aborts at once, so the slave never sees a half-held access.
        act_s     = (state_q == ST_BUSY) && g_req_s && !rst;

        hit_s       = '0;
        s_req_o     = '0;
        s_we_o      = '0;
        s_addr_o    = '0;
        s_wdata_o   = '0;
        slv_ack_s   = 1'b0;
        slv_rdata_s = '0;
        for (int j = 0; j < NUM_S; j++) begin
            hit_s[j]                = act_s && sel_ok_s && (sel_s == SEL_W'(j));
            s_req_o[j]              = hit_s[j];
            s_we_o[j]               = hit_s[j] & g_we_s;
            s_addr_o[j*AW +: AW]    = {AW{hit_s[j]}} & addr_lo_s;
            s_wdata_o[j*DW +: DW]   = {DW{hit_s[j]}} & g_wdata_s;
            slv_ack_s               = slv_ack_s | (hit_s[j] & s_ack_i[j]);
            slv_rdata_s             = slv_rdata_s | ({DW{hit_s[j]}} & s_rdata_i[j*DW +: DW]);
        end
        miss_s = act_s && !sel_ok_s;
        tout_s = act_s && sel_ok_s && !slv_ack_s && (tcnt_q == TCNT_LAST);
        err_s  = miss_s | tout_s;
        done_s = slv_ack_s | err_s;
    end

    // Next-state: grant capture in IDLE; completion, error, abort and timeout counting in BUSY.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                tcnt_d = 8'd0;
                if (|m_req_i) begin
                    grant_d = winner_s;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!g_req_s) begin
                    state_d = ST_IDLE;
                    tcnt_d  = 8'd0;
                end else if (done_s) begin
                    state_d  = ST_IDLE;
                    tcnt_d   = 8'd0;
                    rr_ptr_d = (grant_q == LAST_M) ? '0 : grant_q + GW'(1);
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tcnt_d  = 8'd0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            tcnt_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Master-side responses and pipeline hold; the fetch master idles on a NOP.
    always_comb begin
        m_ack_o     = '0;
        m_err_o     = '0;
        m_rdata_o   = '0;
        other_req_s = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            if (done_s && g_sel_s[k]) begin
                m_ack_o[k]             = 1'b1;
                m_err_o[k]             = err_s;
                m_rdata_o[k*DW +: DW]  = err_s ? '0 : slv_rdata_s;
            end else if (k == IFU_ID) begin
                m_rdata_o[k*DW +: DW]  = IDLE_RDATA;
            end else begin
                m_rdata_o[k*DW +: DW]  = '0;
            end
            other_req_s = other_req_s | (m_req_i[k] & (k != IFU_ID));
        end
        hold_flag_o = !rst && (other_req_s ||
                      ((state_q == ST_BUSY) && (grant_q != GW'(IFU_ID))));
    end
endmodule
